spectrogram_frame_receiver: RTL and testbench

- Receiving end of the spectrogram extractor serial link; sits on the host/FPGA side of the link.
- Samples the `serial_out`/`SL` stream and deserializes each 12-bit word MSB-first. Rebuilds the 16-word frame: word 0 is the RTC word {min[5:0], sec[5:0]}, words 1–15 are channel counts.
- Commits each complete frame atomically into a readable register bank. Flags malformed words and frames.

---
 rtl/spectro_pkg.sv | 20 ++
 rtl/sipo_register.sv | 35 +++
 rtl/spectrogram_frame_receiver.sv | 132 +++++++++++++
 tb/tb_spectrogram_frame_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared constants and FSM state type for the spectrogram link receiver.
package spectro_pkg;

  localparam int WORD_W  = 12;
  localparam int N_WORDS = 16;
  localparam int IDX_W   = 4;

  // RTC word 0 layout: {min[5:0], sec[5:0]}
  localparam int MIN_MSB = 11;
  localparam int MIN_LSB = 6;
  localparam int SEC_MSB = 5;
  localparam int SEC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    SHIFT     = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_register.sv
// Serial-in parallel-out word register with bit counter; mirror of the transmitter PISO.
module sipo_register
  import spectro_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] count
);

  logic full;

  assign full = (count == CNT_W'(WIDTH));

  // Counter saturates at WIDTH so an over-long word cannot corrupt the captured bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en && !full) begin
      word  <= {word[WIDTH-2:0], serial_in};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spectrogram_frame_receiver.sv
// Deserializes the spectrogram serial link into 16-word frames and commits each
// complete frame atomically to a readable register bank.
module spectrogram_frame_receiver
  import spectro_pkg::*;
#(
  parameter int WORD_W  = spectro_pkg::WORD_W,
  parameter int N_WORDS = spectro_pkg::N_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sl,
  input  logic              ovf,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [WORD_W-1:0] word_data,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  output logic              frame_done,
  output logic [5:0]        rtc_min,
  output logic [5:0]        rtc_sec,
  output logic              word_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int          CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned LAST  = N_WORDS - 1;

  state_t             state;
  logic               ovf_q;
  logic               ovf_rise;
  logic [IDX_W-1:0]   idx;
  logic               drop;
  logic [WORD_W-1:0]  shadow [N_WORDS];
  logic [WORD_W-1:0]  bank   [N_WORDS];
  logic [WORD_W-1:0]  sipo_word;
  logic [CNT_W-1:0]   sipo_count;
  logic               sipo_full;
  logic               sipo_clear;
  logic               sipo_shift;

  always_comb begin
    ovf_rise   = ovf & ~ovf_q;
    sipo_full  = (sipo_count == CNT_W'(WORD_W));
    // A restart edge wins over a coincident shift bit, so that bit is never captured
    sipo_clear = ovf_rise || (state == SHIFT && !sl);
    sipo_shift = !ovf_rise && sl && !drop && (state == WAIT_LOAD || state == SHIFT);
  end

  sipo_register #(
    .WIDTH (WORD_W),
    .CNT_W (CNT_W)
  ) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .clear     (sipo_clear),
    .shift_en  (sipo_shift),
    .serial_in (serial_in),
    .word      (sipo_word),
    .count     (sipo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ovf_q      <= 1'b0;
      idx        <= '0;
      drop       <= 1'b0;
      word_data  <= '0;
      word_idx   <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      word_err   <= 1'b0;
      frame_err  <= 1'b0;
      for (int unsigned i = 0; i < N_WORDS; i++) begin
        shadow[i] <= '0;
        bank[i]   <= '0;
      end
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      ovf_q      <= ovf;
      if (ovf_rise) begin
        if (state != IDLE) frame_err <= 1'b1;
        idx   <= '0;
        drop  <= 1'b0;
        state <= WAIT_LOAD;
        for (int unsigned i = 0; i < N_WORDS; i++) shadow[i] <= '0;
      end else begin
        case (state)
          IDLE: ;
          WAIT_LOAD: if (sl) state <= SHIFT;
          SHIFT: begin
            if (sl) begin
              if (sipo_full) begin
                word_err <= 1'b1;
                drop     <= 1'b1;
              end
            end else begin
              state <= WAIT_LOAD;
              drop  <= 1'b0;
              if (!drop && sipo_full) begin
                shadow[idx] <= sipo_word;
                word_data   <= sipo_word;
                word_idx    <= idx;
                word_valid  <= 1'b1;
                idx         <= idx + 1'b1;
                // Last word goes straight into the bank alongside the shadow copy
                if (idx == IDX_W'(LAST)) begin
                  for (int unsigned i = 0; i < N_WORDS; i++)
                    bank[i] <= (i == LAST) ? sipo_word : shadow[i];
                  frame_done <= 1'b1;
                  state      <= IDLE;
                end
              end else if (!drop) begin
                word_err <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rd_data = bank[rd_addr];
  assign rtc_min = bank[0][MIN_MSB:MIN_LSB];
  assign rtc_sec = bank[0][SEC_MSB:SEC_LSB];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// Directed bench for spectrogram_frame_receiver: table-driven frames plus restart/reset sequences.
module tb_spectrogram_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_in;
  logic        sl;
  logic        ovf;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic [11:0] word_data;
  logic [3:0]  word_idx;
  logic        word_valid;
  logic        frame_done;
  logic [5:0]  rtc_min;
  logic [5:0]  rtc_sec;
  logic        word_err;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  spectrogram_frame_receiver #(
    .WORD_W  (12),
    .N_WORDS (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .sl         (sl),
    .ovf        (ovf),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .frame_done (frame_done),
    .rtc_min    (rtc_min),
    .rtc_sec    (rtc_sec),
    .word_err   (word_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ovf_mode: 0 none, 1 ovf pulse with sl low, 2 ovf rising together with sl=1
  typedef struct {
    int          ovf_mode;
    logic [11:0] data;
    int          nbits;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic        exp_done;
    logic        exp_werr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int mode, input int data, input int nbits,
                              input logic v, input int idx, input logic d, input logic we);
    vec_t x;
    x.ovf_mode  = mode;
    x.data      = 12'(data);
    x.nbits     = nbits;
    x.exp_valid = v;
    x.exp_idx   = 4'(idx);
    x.exp_done  = d;
    x.exp_werr  = we;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ovf;
    ovf = 1'b1;
    sl  = 1'b0;
    tick;
    ovf = 1'b0;
  endtask

  task automatic read_bank(input logic [3:0] a, input logic [11:0] exp, input string name);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  // Shifts nbits MSB-first (zeros past bit 11), then one sl=0 cycle, then samples outputs
  task automatic send_word(input logic [11:0] w, input int nbits,
                           output logic v, output logic [3:0] i, output logic [11:0] d,
                           output logic fd, output int stray);
    stray = 0;
    for (int b = 0; b < nbits; b++) begin
      sl        = 1'b1;
      serial_in = (b < 12) ? w[11-b] : 1'b0;
      tick;
      if (word_valid || frame_done) stray++;
    end
    sl        = 1'b0;
    serial_in = 1'b0;
    tick;
    v  = word_valid;
    i  = word_idx;
    d  = word_data;
    fd = frame_done;
  endtask

  task automatic run_vecs(input int first, input int last);
    logic v, fd;
    logic [3:0] i;
    logic [11:0] d;
    int stray;
    for (int n = first; n <= last; n++) begin
      if (vecs[n].ovf_mode == 1) pulse_ovf;
      if (vecs[n].ovf_mode == 2) begin
        ovf = 1'b1; sl = 1'b1; serial_in = 1'b1;
        tick;
        ovf = 1'b0; sl = 1'b0; serial_in = 1'b0;
      end
      send_word(vecs[n].data, vecs[n].nbits, v, i, d, fd, stray);
      chk($sformatf("vec%0d_valid", n), v, vecs[n].exp_valid);
      if (vecs[n].exp_valid) begin
        chk($sformatf("vec%0d_idx", n), i, vecs[n].exp_idx);
        chk($sformatf("vec%0d_data", n), d, vecs[n].data);
      end
      chk($sformatf("vec%0d_done", n), fd, vecs[n].exp_done);
      chk($sformatf("vec%0d_werr", n), word_err, vecs[n].exp_werr);
      chk($sformatf("vec%0d_stray", n), stray, 0);
      chk($sformatf("vec%0d_ferr", n), frame_err, 1'b0);
    end
  endtask

  initial begin
    logic v, fd;
    logic [3:0] i;
    logic [11:0] d;
    int stray, pulses;

    reset = 1'b0; serial_in = 1'b0; sl = 1'b0; ovf = 1'b0; rd_addr = 4'd0;

    // Frame A: word k = 0x100+k, restart edge coincides with sl=1
    for (int k = 0; k < 16; k++) add((k == 0) ? 2 : 0, 'h100 + k, 12, 1'b1, k, k == 15, 1'b0);
    // Frame B: RTC word, short word 3, long word 5
    add(1, 'hA4D, 12, 1'b1, 0, 1'b0, 1'b0);
    add(0, 'h201, 12, 1'b1, 1, 1'b0, 1'b0);
    add(0, 'h202, 12, 1'b1, 2, 1'b0, 1'b0);
    add(0, 'h7FF, 11, 1'b0, 0, 1'b0, 1'b1);
    add(0, 'h203, 12, 1'b1, 3, 1'b0, 1'b1);
    add(0, 'h204, 12, 1'b1, 4, 1'b0, 1'b1);
    add(0, 'h5A5, 14, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 5; k < 16; k++) add(0, 'h200 + k, 12, 1'b1, k, k == 15, 1'b1);

    tick; tick;
    chk("rst_rd_data", rd_data, 12'h0);
    chk("rst_word_data", word_data, 12'h0);
    chk("rst_word_idx", word_idx, 4'h0);
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_rtc", {rtc_min, rtc_sec}, 12'h0);
    chk("rst_errs", {word_err, frame_err}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick;

    run_vecs(0, 15);
    chk("A_busy_end", busy, 1'b0);
    read_bank(4'd7, 12'h107, "A_bank7");
    read_bank(4'd15, 12'h10F, "A_bank15");
    read_bank(4'd0, 12'h100, "A_bank0");

    run_vecs(16, vecs.size() - 1);
    chk("B_rtc_min", rtc_min, 6'd41);
    chk("B_rtc_sec", rtc_sec, 6'd13);
    read_bank(4'd0, 12'hA4D, "B_bank0");
    read_bank(4'd3, 12'h203, "B_bank3");
    read_bank(4'd5, 12'h205, "B_bank5");
    read_bank(4'd15, 12'h20F, "B_bank15");

    // Restart after word 8: bank keeps frame B, new frame commits
    pulse_ovf;
    for (int k = 0; k < 9; k++) begin
      send_word(12'(32'h300 + k), 12, v, i, d, fd, stray);
      chk($sformatf("C_w%0d_idx", k), {v, i}, {1'b1, 4'(k)});
    end
    pulse_ovf;
    chk("C_frame_err", frame_err, 1'b1);
    chk("C_busy", busy, 1'b1);
    read_bank(4'd7, 12'h207, "C_bank7_kept");
    read_bank(4'd8, 12'h208, "C_bank8_kept");
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      send_word(12'(32'h400 + k), 12, v, i, d, fd, stray);
      chk($sformatf("C2_w%0d", k), {v, i, d}, {1'b1, 4'(k), 12'(32'h400 + k)});
      if (fd) pulses++;
    end
    chk("C2_done_last", fd, 1'b1);
    chk("C2_done_count", pulses, 1);
    read_bank(4'd7, 12'h407, "C2_bank7");
    chk("C2_rtc", {rtc_min, rtc_sec}, {6'd16, 6'd0});
    chk("C2_frame_err_sticky", frame_err, 1'b1);

    // Reset during word 10
    pulse_ovf;
    for (int k = 0; k < 10; k++) send_word(12'(32'h500 + k), 12, v, i, d, fd, stray);
    chk("D_w9_idx", word_idx, 4'd9);
    for (int b = 0; b < 5; b++) begin
      sl = 1'b1; serial_in = b[0];
      tick;
    end
    reset = 1'b0;
    #1;
    rd_addr = 4'd7;
    #1;
    chk("D_rd_data", rd_data, 12'h0);
    chk("D_word", {word_data, word_idx}, 16'h0);
    chk("D_pulses", {word_valid, frame_done}, 2'b00);
    chk("D_rtc", {rtc_min, rtc_sec}, 12'h0);
    chk("D_errs", {word_err, frame_err}, 2'b00);
    chk("D_busy", busy, 1'b0);
    tick; tick;
    reset = 1'b1;
    pulses = 0;
    for (int b = 0; b < 27; b++) begin
      sl = (b < 7) ? 1'b1 : 1'b0;
      tick;
      if (frame_done || word_valid || busy) pulses++;
    end
    chk("D_no_activity", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
